// File: rtl/lut_databus_loader.sv
// rtl/lut_databus_loader.sv - databus burst reader that fills the lookup-table RAM, optionally ping-ponging halves
module lut_databus_loader #(
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_DATA_W = 32,
    parameter int ADDR_W     = 10,
    parameter int LEN_W      = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      run,
    input  logic                      running,
    output logic                      done,
    input  logic [AXI_ADDR_W-1:0]     ext_addr,
    input  logic [LEN_W-1:0]          length,
    input  logic                      pingPong,
    input  logic                      disabled,
    output logic                      databus_valid,
    input  logic                      databus_ready,
    output logic [AXI_ADDR_W-1:0]     databus_addr,
    input  logic [AXI_DATA_W-1:0]     databus_rdata,
    output logic [AXI_DATA_W-1:0]     databus_wdata,
    output logic [AXI_DATA_W/8-1:0]   databus_wstrb,
    output logic [LEN_W-1:0]          databus_len,
    input  logic                      databus_last,
    output logic [ADDR_W-1:0]         ram_addr,
    output logic [AXI_DATA_W-1:0]     ram_wdata,
    output logic                      ram_en,
    output logic                      ram_we,
    output logic                      buf_sel
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BURST,
        S_FLUSH
    } state_t;

    state_t state, state_nxt;

    logic [AXI_ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]      len_q;
    logic [LEN_W-1:0]      beat_cnt;
    logic [ADDR_W-1:0]     widx;
    logic                  pp_q;
    logic                  wsel;

    logic start;
    logic beat;
    logic end_beat;

    assign start    = (state == S_IDLE) && run && running && !disabled && (length != '0);
    assign beat     = (state == S_BURST) && databus_valid && databus_ready;
    assign end_beat = beat && ((beat_cnt == len_q - LEN_W'(1)) || databus_last);

    assign databus_addr  = addr_q;
    assign databus_len   = len_q;
    assign databus_wdata = '0;
    assign databus_wstrb = '0;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_BURST;
            S_BURST: if (end_beat) state_nxt = S_FLUSH;
            S_FLUSH: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done          <= 1'b1;
            databus_valid <= 1'b0;
            addr_q        <= '0;
            len_q         <= '0;
            pp_q          <= 1'b0;
            beat_cnt      <= '0;
            widx          <= '0;
            wsel          <= 1'b0;
            buf_sel       <= 1'b0;
            ram_en        <= 1'b0;
            ram_we        <= 1'b0;
            ram_addr      <= '0;
            ram_wdata     <= '0;
        end else begin
            ram_en <= 1'b0;
            ram_we <= 1'b0;

            if (start) begin
                addr_q        <= ext_addr;
                len_q         <= length;
                pp_q          <= pingPong;
                done          <= 1'b0;
                databus_valid <= 1'b1;
                beat_cnt      <= '0;
                widx          <= '0;
            end

            // Each accepted beat lands in RAM one cycle later; the index wraps silently.
            if (beat) begin
                ram_en    <= 1'b1;
                ram_we    <= 1'b1;
                ram_wdata <= databus_rdata;
                ram_addr  <= pp_q ? {wsel, widx[ADDR_W-2:0]} : widx;
                beat_cnt  <= beat_cnt + LEN_W'(1);
                widx      <= widx + ADDR_W'(1);
            end

            if (end_beat) begin
                databus_valid <= 1'b0;
            end

            // The last RAM write is on the port during FLUSH, so the reader may switch now.
            if (state == S_FLUSH) begin
                done <= 1'b1;
                if (pp_q) begin
                    buf_sel <= wsel;
                    wsel    <= ~wsel;
                end
            end
        end
    end

endmodule
